alu_mem_sequencer: RTL and testbench

Multi-cycle controller that sequences the register-file / ALU / single-port RAM datapath for one command at a time. Each command reads operand A from the register file and operand B from RAM, runs one ALU operation, writes the result back to a register, and optionally stores it to the same RAM address. The block drives the datapath control pins in place of the external switch inputs and latches the ALU flags. It keeps a count of completed operations.

---
 rtl/alu_mem_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_mem_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_sequencer.sv
// One-command-at-a-time controller for the register-file / ALU / RAM datapath.
// Latches a command, walks FETCH -> WAIT -> EXEC -> DONE, and counts completions.
module alu_mem_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       cmd_alu_op,
  input  logic [5:0]       cmd_mem_addr,
  input  logic [4:0]       cmd_src,
  input  logic [4:0]       cmd_dst,
  input  logic             cmd_store,
  input  logic             ZF_in,
  input  logic             OF_in,
  output logic [4:0]       R_Addr_A,
  output logic [4:0]       W_Addr,
  output logic             Write_Reg,
  output logic [2:0]       ALU_OP,
  output logic [5:0]       Mem_Addr,
  output logic             Mem_Write,
  output logic             busy,
  output logic             done,
  output logic             ZF_q,
  output logic             OF_q,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_wait_cnt;
  logic [1:0]       w_wait_cnt_next;
  logic [4:0]       r_src;
  logic [4:0]       r_dst;
  logic [2:0]       r_op;
  logic [5:0]       r_addr;
  logic             r_store;
  logic             r_zf;
  logic             r_of;
  logic [CNT_W-1:0] r_count;
  logic             w_latch;

  assign w_latch = (r_state == S_IDLE) && start;

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_FETCH;
      S_FETCH: begin
        if (MEM_LAT == 1) begin
          w_state_next = S_EXEC;
        end else begin
          w_wait_cnt_next = 2'(MEM_LAT - 2);
          w_state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 2'd0) w_state_next = S_EXEC;
        else                    w_wait_cnt_next = r_wait_cnt - 2'd1;
      end
      S_EXEC:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 2'd0;
      r_src      <= '0;
      r_dst      <= '0;
      r_op       <= '0;
      r_addr     <= '0;
      r_store    <= 1'b0;
      r_zf       <= 1'b0;
      r_of       <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_latch) begin
        r_src   <= cmd_src;
        r_dst   <= cmd_dst;
        r_op    <= cmd_alu_op;
        r_addr  <= cmd_mem_addr;
        r_store <= cmd_store;
      end
      if (r_state == S_EXEC) begin
        r_zf <= ZF_in;
        r_of <= OF_in;
      end
      if (r_state == S_DONE) r_count <= r_count + 1'b1;
    end
  end

  // Write strobes are masked by Reset so a reset landing on EXEC commits nothing.
  assign Write_Reg = (r_state == S_EXEC) && !Reset;
  assign Mem_Write = (r_state == S_EXEC) && r_store && !Reset;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign R_Addr_A  = r_src;
  assign W_Addr    = r_dst;
  assign ALU_OP    = r_op;
  assign Mem_Addr  = r_addr;
  assign ZF_q      = r_zf;
  assign OF_q      = r_of;
  assign op_count  = r_count;

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Directed bench: two sequencers (MEM_LAT=1/CNT_W=16 and MEM_LAT=3/CNT_W=2),
// each driving a behavioural register file, RAM and ALU.
module tb_alu_mem_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [2];
  logic       start_s [2];
  logic [2:0] op_s    [2];
  logic [5:0] addr_s  [2];
  logic [4:0] src_s   [2];
  logic [4:0] dst_s   [2];
  logic       st_s    [2];

  logic [4:0] raddr_o [2];
  logic [4:0] waddr_o [2];
  logic       wr_o    [2];
  logic [2:0] aop_o   [2];
  logic [5:0] maddr_o [2];
  logic       mw_o    [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       zfq_o   [2];
  logic       ofq_o   [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  bit [31:0]   rf   [2][32];
  bit [31:0]   mem  [2][64];
  bit [31:0]   pipe [2][4];
  logic [33:0] alu_out [2];
  int          wr_cnt [2];
  int          mw_cnt [2];
  int          both_cnt [2];

  logic        ld_en   [2];
  logic        ld_mem  [2];
  logic [5:0]  ld_addr [2];
  logic [31:0] ld_data [2];

  int n_total = 0;
  int n_bad   = 0;

  bit [2:0]  wrap_op  [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
  bit [4:0]  wrap_dst [4] = '{5'd7, 5'd8, 5'd9, 5'd10};
  bit        wrap_st  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  bit [31:0] wrap_res [4] = '{32'h0000_0001, 32'h7FFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFE};
  bit [1:0]  wrap_cnt [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
  bit        wrap_zf  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  alu_mem_sequencer #(.MEM_LAT(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .Reset(rst[0]), .start(start_s[0]),
    .cmd_alu_op(op_s[0]), .cmd_mem_addr(addr_s[0]), .cmd_src(src_s[0]),
    .cmd_dst(dst_s[0]), .cmd_store(st_s[0]),
    .ZF_in(alu_out[0][32]), .OF_in(alu_out[0][33]),
    .R_Addr_A(raddr_o[0]), .W_Addr(waddr_o[0]), .Write_Reg(wr_o[0]),
    .ALU_OP(aop_o[0]), .Mem_Addr(maddr_o[0]), .Mem_Write(mw_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .ZF_q(zfq_o[0]), .OF_q(ofq_o[0]),
    .op_count(cnt0)
  );

  alu_mem_sequencer #(.MEM_LAT(3), .CNT_W(2)) u_dut1 (
    .clk(clk), .Reset(rst[1]), .start(start_s[1]),
    .cmd_alu_op(op_s[1]), .cmd_mem_addr(addr_s[1]), .cmd_src(src_s[1]),
    .cmd_dst(dst_s[1]), .cmd_store(st_s[1]),
    .ZF_in(alu_out[1][32]), .OF_in(alu_out[1][33]),
    .R_Addr_A(raddr_o[1]), .W_Addr(waddr_o[1]), .Write_Reg(wr_o[1]),
    .ALU_OP(aop_o[1]), .Mem_Addr(maddr_o[1]), .Mem_Write(mw_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .ZF_q(zfq_o[1]), .OF_q(ofq_o[1]),
    .op_count(cnt1)
  );

  // Returns {OF, ZF, result}.
  function automatic logic [33:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd5: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = a << b[4:0];
    endcase
    return {ov, (r == 32'd0), r};
  endfunction

  always_comb begin
    alu_out[0] = alu_f(aop_o[0], rf[0][raddr_o[0]], pipe[0][0]);
    alu_out[1] = alu_f(aop_o[1], rf[1][raddr_o[1]], pipe[1][2]);
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (ld_en[u]) begin
        if (ld_mem[u]) mem[u][ld_addr[u]] <= ld_data[u];
        else           rf[u][ld_addr[u][4:0]] <= ld_data[u];
      end
      if (wr_o[u]) begin
        rf[u][waddr_o[u]] <= alu_out[u][31:0];
        wr_cnt[u] <= wr_cnt[u] + 1;
      end
      if (mw_o[u]) begin
        mem[u][maddr_o[u]] <= alu_out[u][31:0];
        mw_cnt[u] <= mw_cnt[u] + 1;
      end
      if (wr_o[u] && mw_o[u]) both_cnt[u] <= both_cnt[u] + 1;
      pipe[u][0] <= mem[u][maddr_o[u]];
      for (int k = 1; k < 4; k++) pipe[u][k] <= pipe[u][k-1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int u, input logic is_mem, input logic [5:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    ld_en[u] = 1'b1; ld_mem[u] = is_mem; ld_addr[u] = a; ld_data[u] = d;
    @(negedge clk);
    ld_en[u] = 1'b0;
  endtask

  // Issues one command and follows it until done (bounded). Cycle 1 is FETCH.
  task automatic run_cmd(input int u, input logic [2:0] op, input logic [5:0] a,
                         input logic [4:0] src, input logic [4:0] dst, input logic st,
                         output int done_cyc, output int wr_cyc, output int wr_n,
                         output logic [18:0] fv);
    @(negedge clk);
    op_s[u] = op; addr_s[u] = a; src_s[u] = src; dst_s[u] = dst; st_s[u] = st;
    start_s[u] = 1'b1;
    @(negedge clk);
    start_s[u] = 1'b0;
    done_cyc = -1; wr_cyc = -1; wr_n = 0; fv = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) fv = {raddr_o[u], waddr_o[u], aop_o[u], maddr_o[u]};
      if (wr_o[u]) begin
        wr_n++;
        if (wr_cyc < 0) wr_cyc = c;
      end
      if (done_o[u]) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          dc, wc, wn, base_w, base_m, base_b;
    logic [18:0] fv;
    logic [7:0]  bb;
    int          w1c, w2c;
    logic [4:0]  w1a, w2a;

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; start_s[u] = 1'b0; op_s[u] = '0; addr_s[u] = '0;
      src_s[u] = '0; dst_s[u] = '0; st_s[u] = 1'b0;
      ld_en[u] = 1'b0; ld_mem[u] = 1'b0; ld_addr[u] = '0; ld_data[u] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ctl0", 32'({busy_o[0], done_o[0], wr_o[0], mw_o[0], zfq_o[0], ofq_o[0]}), 32'd0);
    check("rst_addr0", 32'({raddr_o[0], waddr_o[0], aop_o[0], maddr_o[0]}), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_ctl1", 32'({busy_o[1], done_o[1], wr_o[1], mw_o[1], zfq_o[1], ofq_o[1]}), 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Add, MEM_LAT=1
    poke(0, 1'b0, 6'd3, 32'h0000_0005);
    poke(0, 1'b1, 6'd10, 32'h0000_0003);
    run_cmd(0, 3'd4, 6'd10, 5'd3, 5'd4, 1'b0, dc, wc, wn, fv);
    check("add_fetch_fields", 32'(fv), 32'({5'd3, 5'd4, 3'd4, 6'd10}));
    check("add_wr_cycle", 32'(wc), 32'd2);
    check("add_wr_count", 32'(wn), 32'd1);
    check("add_done_cycle", 32'(dc), 32'd3);
    check("add_reg4", rf[0][4], 32'h0000_0008);
    check("add_flags", 32'({zfq_o[0], ofq_o[0]}), 32'd0);
    check("add_opcount", 32'(cnt0), 32'd1);
    check("add_memwr", 32'(mw_cnt[0]), 32'd0);
    check("add_idle", 32'(busy_o[0]), 32'd0);

    // Sub to zero with store, dst == src
    poke(0, 1'b0, 6'd1, 32'h0000_0003);
    poke(0, 1'b1, 6'd5, 32'h0000_0003);
    base_b = both_cnt[0];
    run_cmd(0, 3'd5, 6'd5, 5'd1, 5'd1, 1'b1, dc, wc, wn, fv);
    check("sub_reg1", rf[0][1], 32'd0);
    check("sub_mem5", mem[0][5], 32'd0);
    check("sub_same_edge", 32'(both_cnt[0] - base_b), 32'd1);
    check("sub_flags", 32'({zfq_o[0], ofq_o[0]}), 32'b10);
    check("sub_opcount", 32'(cnt0), 32'd2);

    // Overflow with MEM_LAT=3, first of five commands on the CNT_W=2 unit
    poke(1, 1'b0, 6'd2, 32'h7FFF_FFFF);
    poke(1, 1'b1, 6'd0, 32'h0000_0001);
    run_cmd(1, 3'd4, 6'd0, 5'd2, 5'd6, 1'b0, dc, wc, wn, fv);
    check("ovf_reg6", rf[1][6], 32'h8000_0000);
    check("ovf_flags", 32'({zfq_o[1], ofq_o[1]}), 32'b01);
    check("ovf_done_cycle", 32'(dc), 32'd5);
    check("ovf_wr_cycle", 32'(wc), 32'd4);
    check("ovf_opcount", 32'(cnt1), 32'd1);

    for (int i = 0; i < 4; i++) begin
      run_cmd(1, wrap_op[i], 6'd0, 5'd2, wrap_dst[i], wrap_st[i], dc, wc, wn, fv);
      check($sformatf("wrap%0d_res", i), rf[1][wrap_dst[i]], wrap_res[i]);
      check($sformatf("wrap%0d_cnt", i), 32'(cnt1), 32'(wrap_cnt[i]));
      check($sformatf("wrap%0d_zf", i), 32'(zfq_o[1]), 32'(wrap_zf[i]));
    end
    check("wrap_store_mem0", mem[1][0], 32'hFFFF_FFFE);

    // start held high, dst changed during FETCH
    poke(0, 1'b0, 6'd7, 32'h0000_0066);
    poke(0, 1'b0, 6'd9, 32'h0000_0055);
    @(negedge clk);
    op_s[0] = 3'd4; addr_s[0] = 6'd10; src_s[0] = 5'd3; dst_s[0] = 5'd7; st_s[0] = 1'b0;
    start_s[0] = 1'b1;
    @(negedge clk);
    dst_s[0] = 5'd9;
    bb = '0; w1c = -1; w2c = -1; w1a = '0; w2a = '0;
    for (int c = 1; c <= 8; c++) begin
      bb[c-1] = busy_o[0];
      if (wr_o[0]) begin
        if (w1c < 0) begin w1c = c; w1a = waddr_o[0]; end
        else if (w2c < 0) begin w2c = c; w2a = waddr_o[0]; end
      end
      if (c == 5) start_s[0] = 1'b0;
      @(negedge clk);
    end
    check("hold_busy_pattern", 32'(bb), 32'h77);
    check("hold_first_wr", 32'({w1c[7:0], 3'b0, w1a}), 32'({8'd2, 3'b0, 5'd7}));
    check("hold_second_wr", 32'({w2c[7:0], 3'b0, w2a}), 32'({8'd6, 3'b0, 5'd9}));
    check("hold_reg7", rf[0][7], 32'h0000_0008);
    check("hold_reg9", rf[0][9], 32'h0000_0008);
    check("hold_opcount", 32'(cnt0), 32'd4);

    // Reset landing on EXEC
    poke(0, 1'b0, 6'd12, 32'h0000_00AA);
    base_w = wr_cnt[0];
    base_m = mw_cnt[0];
    @(negedge clk);
    op_s[0] = 3'd4; addr_s[0] = 6'd10; src_s[0] = 5'd3; dst_s[0] = 5'd12; st_s[0] = 1'b1;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    check("rstmid_in_exec", 32'({wr_o[0], mw_o[0]}), 32'b11);
    rst[0] = 1'b1;
    #1;
    check("rstmid_strobes_masked", 32'({wr_o[0], mw_o[0]}), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    check("rstmid_ctl", 32'({busy_o[0], done_o[0], wr_o[0], mw_o[0], zfq_o[0], ofq_o[0]}), 32'd0);
    check("rstmid_addr", 32'({raddr_o[0], waddr_o[0], aop_o[0], maddr_o[0]}), 32'd0);
    check("rstmid_cnt", 32'(cnt0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_no_regwr", 32'(wr_cnt[0] - base_w), 32'd0);
    check("rstmid_no_memwr", 32'(mw_cnt[0] - base_m), 32'd0);
    check("rstmid_reg12", rf[0][12], 32'h0000_00AA);
    check("rstmid_mem10", mem[0][10], 32'h0000_0003);
    check("rstmid_idle", 32'(busy_o[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
